// File: rtl/mem_rdata_tracker_pkg.sv
// Shared defaults and helpers for the MEM-stage load-response tracker.
// Holds the bus defaults, the counter width derivation and the error-cause record.
package mem_rdata_tracker_pkg;

    localparam int MEM_DATA_W        = 32;
    localparam int MEM_MAX_OUTST     = 4;
    localparam int MEM_RSP_BUF_DEPTH = 2;

    // Width needed to hold 0..max_outst inclusive.
    function automatic int cnt_w(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

    typedef struct packed {
        logic orphan_rsp;   // response with nothing in flight
        logic req_blocked;  // request issued while not allowed
        logic fifo_ovf;     // push into a full response buffer
        logic cnt_ovf;      // a counter would pass MAX_OUTST
    } err_cause_t;

endpackage

// File: rtl/mem_rdata_tracker_if.sv
// Request/response bus between the dcache, the MEM stage and the load-response tracker.
// The master side is the pipeline/cache environment; the slave side is the tracker.
interface mem_rdata_tracker_if
    import mem_rdata_tracker_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int CNT_W  = cnt_w(MEM_MAX_OUTST)
);

    logic              req_fire;
    logic              req_allow;
    logic              flush;
    logic              cache_rdata_ok;
    logic [DATA_W-1:0] cache_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [CNT_W-1:0]  live_cnt;
    logic [CNT_W-1:0]  cancel_cnt;
    logic              error;

    modport master (
        output req_fire,
        output flush,
        output cache_rdata_ok,
        output cache_rdata,
        output rsp_ready,
        input  req_allow,
        input  rsp_valid,
        input  rsp_data,
        input  live_cnt,
        input  cancel_cnt,
        input  error
    );

    modport slave (
        input  req_fire,
        input  flush,
        input  cache_rdata_ok,
        input  cache_rdata,
        input  rsp_ready,
        output req_allow,
        output rsp_valid,
        output rsp_data,
        output live_cnt,
        output cancel_cnt,
        output error
    );

endinterface

// File: rtl/mem_rsp_fifo.sv
// Small synchronous response FIFO with a combinational head (first-word fall-through).
// Push while full is accepted only when the head pops in the same cycle.
module mem_rsp_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             wr_en;
    logic             rd_en;

    // Explicit wrap keeps DEPTH=1 working with a 1-bit pointer.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign wr_en = push && !clear && (!full || pop);
    assign rd_en = pop && !clear && !empty;
    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (rd_en) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/mem_rdata_tracker.sv
// MEM-stage load-response tracker: counts live and flush-cancelled reads in flight,
// drops orphaned responses and returns live ones in order, bypassing the buffer when possible.
module mem_rdata_tracker
    import mem_rdata_tracker_pkg::*;
#(
    parameter int DATA_W    = MEM_DATA_W,
    parameter int MAX_OUTST = MEM_MAX_OUTST,
    parameter int BUF_DEPTH = MEM_RSP_BUF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    mem_rdata_tracker_if.slave bus
);

    localparam int          CNT_W   = cnt_w(MAX_OUTST);
    localparam int          FCNT_W  = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0] MAX_W   = 32'(MAX_OUTST);
    localparam logic [31:0] DEPTH_W = 32'(BUF_DEPTH);

    logic [CNT_W-1:0]  live_cnt_reg;
    logic [CNT_W-1:0]  live_cnt_next;
    logic [CNT_W-1:0]  cancel_cnt_reg;
    logic [CNT_W-1:0]  cancel_cnt_next;
    logic              error_reg;
    logic              error_next;

    logic [31:0]       live_sum;
    logic [31:0]       cancel_sum;
    logic              rsp_live;
    logic              rsp_cancel;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              req_allow;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FCNT_W-1:0] fifo_cnt;
    logic [DATA_W-1:0] fifo_dout;
    err_cause_t        err_cause;

    // Cancelled requests are always the oldest, so they own the next responses.
    // A response with nothing in flight has no owner and is discarded.
    assign rsp_cancel = bus.cache_rdata_ok && (cancel_cnt_reg != '0);
    assign rsp_live   = bus.cache_rdata_ok && (cancel_cnt_reg == '0) && (live_cnt_reg != '0);

    assign bypass = rsp_live && fifo_empty && bus.rsp_ready && !bus.flush;
    assign push   = rsp_live && !bypass && !bus.flush;
    assign pop    = !fifo_empty && bus.rsp_ready && !bus.flush;

    assign rsp_valid = !bus.flush && (!fifo_empty || bypass);

    always_comb begin
        rsp_data = '0;
        if (!bus.flush) begin
            if (!fifo_empty) begin
                rsp_data = fifo_dout;
            end else if (bypass) begin
                rsp_data = bus.cache_rdata;
            end
        end
    end

    // Reserving a buffer slot per live request means a late response can always be parked.
    assign req_allow = ((32'(live_cnt_reg) + 32'(cancel_cnt_reg)) < MAX_W) &&
                       ((32'(live_cnt_reg) + 32'(fifo_cnt)) < DEPTH_W);

    mem_rsp_fifo #(
        .W     (DATA_W),
        .DEPTH (BUF_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (bus.flush),
        .din   (bus.cache_rdata),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_cnt)
    );

    // Counter arithmetic is done wide so overflow can be detected and clamped.
    always_comb begin
        live_sum   = 32'(live_cnt_reg);
        cancel_sum = 32'(cancel_cnt_reg);
        if (bus.flush) begin
            cancel_sum = cancel_sum + live_sum + 32'(bus.req_fire);
            if (bus.cache_rdata_ok && (cancel_sum != '0)) begin
                cancel_sum = cancel_sum - 32'd1;
            end
            live_sum = '0;
        end else begin
            if (bus.req_fire) begin
                live_sum = live_sum + 32'd1;
            end
            if (rsp_live) begin
                live_sum = live_sum - 32'd1;
            end
            if (rsp_cancel) begin
                cancel_sum = cancel_sum - 32'd1;
            end
        end
    end

    assign live_cnt_next   = (live_sum > MAX_W)   ? CNT_W'(MAX_OUTST) : live_sum[CNT_W-1:0];
    assign cancel_cnt_next = (cancel_sum > MAX_W) ? CNT_W'(MAX_OUTST) : cancel_sum[CNT_W-1:0];

    always_comb begin
        err_cause             = '0;
        err_cause.orphan_rsp  = bus.cache_rdata_ok && (live_cnt_reg == '0) && (cancel_cnt_reg == '0);
        err_cause.req_blocked = bus.req_fire && !req_allow;
        err_cause.fifo_ovf    = push && fifo_full && !pop;
        err_cause.cnt_ovf     = (live_sum > MAX_W) || (cancel_sum > MAX_W);
    end

    assign error_next = error_reg || (|err_cause);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_cnt_reg   <= '0;
            cancel_cnt_reg <= '0;
            error_reg      <= 1'b0;
        end else begin
            live_cnt_reg   <= live_cnt_next;
            cancel_cnt_reg <= cancel_cnt_next;
            error_reg      <= error_next;
        end
    end

    assign bus.req_allow  = req_allow;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data;
    assign bus.live_cnt   = live_cnt_reg;
    assign bus.cancel_cnt = cancel_cnt_reg;
    assign bus.error      = error_reg;

endmodule

// File: tb/tb_mem_rdata_tracker.sv
// Directed and random checks of mem_rdata_tracker: dut_a uses the default 2-entry buffer,
// dut_b a 4-entry buffer so that deep-cancel scenarios are reachable.
module tb_mem_rdata_tracker;
    import mem_rdata_tracker_pkg::*;

    localparam int CW = cnt_w(4);

    typedef struct {
        logic [31:0] data;
        bit          cancelled;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_rdata_tracker_if #(.DATA_W(32), .CNT_W(CW)) bus_a ();
    mem_rdata_tracker_if #(.DATA_W(32), .CNT_W(CW)) bus_b ();

    mem_rdata_tracker #(.DATA_W(32), .MAX_OUTST(4), .BUF_DEPTH(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mem_rdata_tracker #(.DATA_W(32), .MAX_OUTST(4), .BUF_DEPTH(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic fire, input logic fl, input logic ok,
                           input logic [31:0] d, input logic rdy);
        bus_a.req_fire       = fire;
        bus_a.flush          = fl;
        bus_a.cache_rdata_ok = ok;
        bus_a.cache_rdata    = d;
        bus_a.rsp_ready      = rdy;
    endtask

    task automatic drive_b(input logic fire, input logic fl, input logic ok,
                           input logic [31:0] d, input logic rdy);
        bus_b.req_fire       = fire;
        bus_b.flush          = fl;
        bus_b.cache_rdata_ok = ok;
        bus_b.cache_rdata    = d;
        bus_b.rsp_ready      = rdy;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive_a(0, 0, 0, 32'h0, 0);
        drive_b(0, 0, 0, 32'h0, 0);
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (bus_a.req_allow !== 1'b1) begin errors++; $display("FAIL reset_allow: got %b expected 1", bus_a.req_allow); end
        checks++; if (bus_a.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus_a.rsp_valid); end
        checks++; if (bus_a.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus_a.rsp_data); end
        checks++; if (bus_a.live_cnt !== 3'd0) begin errors++; $display("FAIL reset_live: got %0d expected 0", bus_a.live_cnt); end
        checks++; if (bus_a.cancel_cnt !== 3'd0) begin errors++; $display("FAIL reset_cancel: got %0d expected 0", bus_a.cancel_cnt); end
        checks++; if (bus_a.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus_a.error); end
        checks++; if (bus_b.req_allow !== 1'b1) begin errors++; $display("FAIL reset_allow_b: got %b expected 1", bus_b.req_allow); end
        $display("test_reset: done");
    endtask

    task automatic test_bypass();
        drive_a(1, 0, 0, 32'h0, 1);
        cycle();
        drive_a(0, 0, 0, 32'h0, 1);
        checks++; if (bus_a.live_cnt !== 3'd1) begin errors++; $display("FAIL bypass_live_after_req: got %0d expected 1", bus_a.live_cnt); end
        cycle();
        drive_a(0, 0, 1, 32'h1234, 1);
        #1;
        checks++; if (bus_a.rsp_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b expected 1", bus_a.rsp_valid); end
        checks++; if (bus_a.rsp_data !== 32'h1234) begin errors++; $display("FAIL bypass_data: got %h expected 00001234", bus_a.rsp_data); end
        $display("test_bypass: response %h", bus_a.rsp_data);
        cycle();
        drive_a(0, 0, 0, 32'h0, 1);
        #1;
        checks++; if (bus_a.live_cnt !== 3'd0) begin errors++; $display("FAIL bypass_live_after_rsp: got %0d expected 0", bus_a.live_cnt); end
        checks++; if (bus_a.rsp_valid !== 1'b0) begin errors++; $display("FAIL bypass_valid_after: got %b expected 0", bus_a.rsp_valid); end
    endtask

    task automatic test_buffered();
        drive_a(1, 0, 0, 32'h0, 0);
        cycle();
        checks++; if (bus_a.req_allow !== 1'b1) begin errors++; $display("FAIL buf_allow_1: got %b expected 1", bus_a.req_allow); end
        drive_a(1, 0, 0, 32'h0, 0);
        cycle();
        checks++; if (bus_a.live_cnt !== 3'd2) begin errors++; $display("FAIL buf_live_2: got %0d expected 2", bus_a.live_cnt); end
        checks++; if (bus_a.req_allow !== 1'b0) begin errors++; $display("FAIL buf_allow_2: got %b expected 0", bus_a.req_allow); end
        drive_a(0, 0, 1, 32'hA, 0);
        #1;
        checks++; if (bus_a.rsp_valid !== 1'b0) begin errors++; $display("FAIL buf_no_bypass: got %b expected 0", bus_a.rsp_valid); end
        cycle();
        drive_a(0, 0, 1, 32'hB, 0);
        #1;
        checks++; if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== 32'hA) begin errors++; $display("FAIL buf_head_first: got valid %b data %h expected 1 0000000a", bus_a.rsp_valid, bus_a.rsp_data); end
        cycle();
        checks++; if (bus_a.live_cnt !== 3'd0) begin errors++; $display("FAIL buf_live_0: got %0d expected 0", bus_a.live_cnt); end
        checks++; if (bus_a.req_allow !== 1'b0) begin errors++; $display("FAIL buf_full_allow: got %b expected 0", bus_a.req_allow); end
        drive_a(0, 0, 0, 32'h0, 1);
        #1;
        checks++; if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== 32'hA) begin errors++; $display("FAIL buf_pop_a: got valid %b data %h expected 1 0000000a", bus_a.rsp_valid, bus_a.rsp_data); end
        $display("test_buffered: response %h", bus_a.rsp_data);
        cycle();
        checks++; if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== 32'hB) begin errors++; $display("FAIL buf_pop_b: got valid %b data %h expected 1 0000000b", bus_a.rsp_valid, bus_a.rsp_data); end
        $display("test_buffered: response %h", bus_a.rsp_data);
        cycle();
        checks++; if (bus_a.rsp_valid !== 1'b0) begin errors++; $display("FAIL buf_drained_valid: got %b expected 0", bus_a.rsp_valid); end
        checks++; if (bus_a.req_allow !== 1'b1) begin errors++; $display("FAIL buf_drained_allow: got %b expected 1", bus_a.req_allow); end
    endtask

    task automatic test_flush_with_req();
        repeat (3) begin
            drive_b(1, 0, 0, 32'h0, 1);
            cycle();
        end
        checks++; if (bus_b.live_cnt !== 3'd3) begin errors++; $display("FAIL fl_live_3: got %0d expected 3", bus_b.live_cnt); end
        drive_b(1, 1, 0, 32'h0, 1);
        #1;
        checks++; if (bus_b.rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_valid_in_flush: got %b expected 0", bus_b.rsp_valid); end
        cycle();
        checks++; if (bus_b.cancel_cnt !== 3'd4) begin errors++; $display("FAIL fl_cancel_4: got %0d expected 4", bus_b.cancel_cnt); end
        checks++; if (bus_b.live_cnt !== 3'd0) begin errors++; $display("FAIL fl_live_0: got %0d expected 0", bus_b.live_cnt); end
        checks++; if (bus_b.req_allow !== 1'b0) begin errors++; $display("FAIL fl_allow_0: got %b expected 0", bus_b.req_allow); end
        for (int k = 0; k < 4; k++) begin
            drive_b(0, 0, 1, 32'h100 + 32'(k), 1);
            #1;
            checks++; if (bus_b.rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_drop_%0d: got valid %b expected 0", k, bus_b.rsp_valid); end
            cycle();
        end
        checks++; if (bus_b.cancel_cnt !== 3'd0) begin errors++; $display("FAIL fl_cancel_drained: got %0d expected 0", bus_b.cancel_cnt); end
        drive_b(1, 0, 0, 32'h0, 1);
        cycle();
        drive_b(0, 0, 1, 32'h55, 1);
        #1;
        checks++; if (bus_b.rsp_valid !== 1'b1 || bus_b.rsp_data !== 32'h55) begin errors++; $display("FAIL fl_fifth: got valid %b data %h expected 1 00000055", bus_b.rsp_valid, bus_b.rsp_data); end
        $display("test_flush_with_req: response %h", bus_b.rsp_data);
        cycle();
        drive_b(0, 0, 0, 32'h0, 0);
        checks++; if (bus_b.live_cnt !== 3'd0) begin errors++; $display("FAIL fl_live_end: got %0d expected 0", bus_b.live_cnt); end
        checks++; if (bus_b.error !== 1'b0) begin errors++; $display("FAIL fl_error: got %b expected 0", bus_b.error); end
    endtask

    task automatic test_flush_with_rsp();
        repeat (3) begin
            drive_b(1, 0, 0, 32'h0, 0);
            cycle();
        end
        drive_b(0, 0, 1, 32'h11, 0);
        cycle();
        checks++; if (bus_b.live_cnt !== 3'd2 || bus_b.rsp_valid !== 1'b1 || bus_b.rsp_data !== 32'h11) begin
            errors++; $display("FAIL flr_setup: got live %0d valid %b data %h expected 2 1 00000011", bus_b.live_cnt, bus_b.rsp_valid, bus_b.rsp_data); end
        drive_b(0, 1, 1, 32'h22, 1);
        #1;
        checks++; if (bus_b.rsp_valid !== 1'b0) begin errors++; $display("FAIL flr_valid_in_flush: got %b expected 0", bus_b.rsp_valid); end
        cycle();
        drive_b(0, 0, 0, 32'h0, 1);
        #1;
        checks++; if (bus_b.cancel_cnt !== 3'd1) begin errors++; $display("FAIL flr_cancel_1: got %0d expected 1", bus_b.cancel_cnt); end
        checks++; if (bus_b.live_cnt !== 3'd0) begin errors++; $display("FAIL flr_live_0: got %0d expected 0", bus_b.live_cnt); end
        checks++; if (bus_b.rsp_valid !== 1'b0) begin errors++; $display("FAIL flr_fifo_cleared: got valid %b expected 0", bus_b.rsp_valid); end
        drive_b(0, 0, 1, 32'h33, 1);
        #1;
        checks++; if (bus_b.rsp_valid !== 1'b0) begin errors++; $display("FAIL flr_drop: got valid %b expected 0", bus_b.rsp_valid); end
        cycle();
        drive_b(0, 0, 0, 32'h0, 0);
        checks++; if (bus_b.cancel_cnt !== 3'd0 || bus_b.error !== 1'b0) begin
            errors++; $display("FAIL flr_end: got cancel %0d error %b expected 0 0", bus_b.cancel_cnt, bus_b.error); end
        $display("test_flush_with_rsp: done");
    endtask

    task automatic test_errors();
        drive_a(0, 0, 1, 32'hDEAD, 1);
        cycle();
        drive_a(0, 0, 0, 32'h0, 1);
        checks++; if (bus_a.error !== 1'b1) begin errors++; $display("FAIL err_orphan: got %b expected 1", bus_a.error); end
        repeat (3) cycle();
        checks++; if (bus_a.error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus_a.error); end
        reset_dut();
        checks++; if (bus_a.error !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", bus_a.error); end
        repeat (2) begin
            drive_a(1, 0, 0, 32'h0, 0);
            cycle();
        end
        checks++; if (bus_a.error !== 1'b0 || bus_a.req_allow !== 1'b0) begin
            errors++; $display("FAIL err_pre_block: got error %b allow %b expected 0 0", bus_a.error, bus_a.req_allow); end
        drive_a(1, 0, 0, 32'h0, 0);
        cycle();
        drive_a(0, 0, 0, 32'h0, 0);
        checks++; if (bus_a.error !== 1'b1) begin errors++; $display("FAIL err_blocked_req: got %b expected 1", bus_a.error); end
        rst = 1'b1;
        #1;
        checks++; if (bus_a.live_cnt !== 3'd0 || bus_a.error !== 1'b0 || bus_a.req_allow !== 1'b1) begin
            errors++; $display("FAIL err_async_reset: got live %0d error %b allow %b expected 0 0 1", bus_a.live_cnt, bus_a.error, bus_a.req_allow); end
        cycle();
        rst = 1'b0;
        $display("test_errors: done");
    endtask

    task automatic test_random_traffic();
        req_t        pending[$];
        logic [31:0] owed[$];
        req_t        r;
        int          exp_live;
        int          exp_cancel;
        int          owed_before;
        int          delivered;
        bit          exp_allow;
        bit          exp_valid;
        bit          arrive_live;
        bit          fire;
        bit          fl;
        bit          ok;
        bit          rdy;
        logic [31:0] d;
        delivered = 0;
        reset_dut();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            exp_live   = 0;
            exp_cancel = 0;
            foreach (pending[i]) begin
                if (pending[i].cancelled) exp_cancel++;
                else exp_live++;
            end
            exp_allow = ((exp_live + exp_cancel) < 4) && ((exp_live + owed.size()) < 2);
            checks++; if (bus_a.live_cnt !== 3'(exp_live)) begin errors++; $display("FAIL rnd_live cyc %0d: got %0d expected %0d", cyc, bus_a.live_cnt, exp_live); end
            checks++; if (bus_a.cancel_cnt !== 3'(exp_cancel)) begin errors++; $display("FAIL rnd_cancel cyc %0d: got %0d expected %0d", cyc, bus_a.cancel_cnt, exp_cancel); end
            checks++; if (bus_a.req_allow !== exp_allow) begin errors++; $display("FAIL rnd_allow cyc %0d: got %b expected %b", cyc, bus_a.req_allow, exp_allow); end
            checks++; if ((int'(bus_a.live_cnt) + int'(bus_a.cancel_cnt)) > 4) begin
                errors++; $display("FAIL rnd_outst cyc %0d: got %0d expected <= 4", cyc, int'(bus_a.live_cnt) + int'(bus_a.cancel_cnt)); end

            fire = exp_allow && ($urandom_range(2) != 0);
            fl   = ($urandom_range(49) == 0);
            ok   = (pending.size() > 0) && ($urandom_range(1) == 0);
            rdy  = ($urandom_range(3) != 0);
            d    = ok ? pending[0].data : 32'h0;
            drive_a(fire, fl, ok, d, rdy);
            #1;

            owed_before = owed.size();
            arrive_live = 1'b0;
            if (ok) begin
                r = pending.pop_front();
                if (!r.cancelled && !fl) begin
                    owed.push_back(r.data);
                    arrive_live = 1'b1;
                end
            end
            if (fl) begin
                owed.delete();
                foreach (pending[i]) pending[i].cancelled = 1'b1;
            end
            if (fire) begin
                r.data      = $urandom();
                r.cancelled = fl;
                pending.push_back(r);
            end

            exp_valid = !fl && ((owed_before > 0) || (arrive_live && rdy));
            checks++; if (bus_a.rsp_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", cyc, bus_a.rsp_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (bus_a.rsp_data !== owed[0]) begin errors++; $display("FAIL rnd_data cyc %0d: got %h expected %h", cyc, bus_a.rsp_data, owed[0]); end
                if (rdy) begin
                    void'(owed.pop_front());
                    delivered++;
                end
            end
            cycle();
        end
        drive_a(0, 0, 0, 32'h0, 0);
        checks++; if (bus_a.error !== 1'b0) begin errors++; $display("FAIL rnd_error: got %b expected 0", bus_a.error); end
        $display("test_random_traffic: %0d responses delivered", delivered);
    endtask

    initial begin
        drive_a(0, 0, 0, 32'h0, 0);
        drive_b(0, 0, 0, 32'h0, 0);
        test_reset();
        test_bypass();
        test_buffered();
        test_flush_with_req();
        test_flush_with_rsp();
        test_errors();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
